mul_div_unit: RTL and testbench

Iterative multiply/divide unit for the single-cycle CPU, downstream of the register file: it consumes the two read-port operands (A, B) on MULT/MULTU/DIV/DIVU and holds the 64-bit result in the HI/LO registers. The unit runs for several cycles while the control path stalls on Busy. HI/LO are read back by MFHI/MFLO and written by MTHI/MTLO.

---
 rtl/muldiv_pkg.sv | 20 ++
 rtl/muldiv_signfix.sv | 32 +++
 rtl/mul_div_unit.sv | 153 +++++++++++++++
 tb/tb_mul_div_unit.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Op encoding follows the CPU decode of MULT/MULTU/DIV/DIVU.
package muldiv_pkg;

  localparam int ITER = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_signfix.sv
// Sign correction applied to the unsigned magnitude result in FIX:
// negates the 64-bit product, or the quotient and remainder independently.
module muldiv_signfix
  import muldiv_pkg::*;
#(
  parameter int WIDTH = ITER
) (
  input  logic             is_div,
  input  logic             neg_q,
  input  logic             neg_r,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  logic [2*WIDTH-1:0] prod_neg;

  assign prod_neg = -{hi_in, lo_in};

  always_comb begin
    hi_out = hi_in;
    lo_out = lo_in;
    if (!is_div) begin
      if (neg_q) {hi_out, lo_out} = prod_neg;
    end else begin
      if (neg_r) hi_out = -hi_in;
      if (neg_q) lo_out = -lo_in;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit feeding the HI/LO registers.
// Optional MULDIV_FAST_MUL_EN replaces the shift-add multiply with a one-cycle multiplier.
//
// state | meaning
// IDLE  | waiting for Start; MTHI/MTLO honoured
// CALC  | one multiply or divide bit per cycle, counter runs down
// FIX   | sign correction, HI/LO written, Done next cycle
module mul_div_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = ITER
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             HiWrite,
  input  logic             LoWrite,
  input  logic [WIDTH-1:0] WData,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int W2    = 2 * WIDTH;

  state_e             state, state_nxt;
  op_e                op_in, op_q;
  logic [CNT_W-1:0]   cnt;
  logic [W2-1:0]      acc, acc_init;
  logic [WIDTH:0]     rem;
  logic [WIDTH-1:0]   dvsr, a_orig, a_mag, b_mag;
  logic [WIDTH-1:0]   hi_q, lo_q, fix_hi, fix_lo;
  logic               neg_q, neg_r, b_zero, done_q, divzero_q;
  logic               signed_in, div_in, is_div, fast_start;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   rem_sh, rem_diff;

  assign op_in     = op_e'(Op);
  assign signed_in = (op_in == OP_MULT) || (op_in == OP_DIV);
  assign div_in    = (op_in == OP_DIV) || (op_in == OP_DIVU);
  assign is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign a_mag     = (signed_in && A[WIDTH-1]) ? -A : A;
  assign b_mag     = (signed_in && B[WIDTH-1]) ? -B : B;

`ifdef MULDIV_FAST_MUL_EN
  assign fast_start = !div_in;
  assign acc_init   = div_in ? {{WIDTH{1'b0}}, a_mag} : W2'(a_mag) * W2'(b_mag);
`else
  assign fast_start = 1'b0;
  assign acc_init   = {{WIDTH{1'b0}}, a_mag};
`endif

  // multiplier bits are consumed from acc[0]; product grows in from the top
  assign mul_sum  = {1'b0, acc[W2-1:WIDTH]} + (acc[0] ? {1'b0, dvsr} : '0);
  assign rem_sh   = {rem, acc[WIDTH-1]};
  assign rem_diff = rem_sh - {2'b00, dvsr};

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = fast_start ? FIX : CALC;
      CALC:    if (cnt == '0) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
    .is_div (is_div),
    .neg_q  (neg_q),
    .neg_r  (neg_r),
    .hi_in  (is_div ? rem[WIDTH-1:0] : acc[W2-1:WIDTH]),
    .lo_in  (acc[WIDTH-1:0]),
    .hi_out (fix_hi),
    .lo_out (fix_lo)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      op_q      <= OP_MULT;
      cnt       <= '0;
      acc       <= '0;
      rem       <= '0;
      dvsr      <= '0;
      a_orig    <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      b_zero    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      done_q <= (state == FIX);
      case (state)
        IDLE: begin
          if (HiWrite) hi_q <= WData;
          if (LoWrite) lo_q <= WData;
          if (Start) begin
            op_q      <= op_in;
            acc       <= acc_init;
            rem       <= '0;
            dvsr      <= b_mag;
            a_orig    <= A;
            neg_q     <= signed_in && (A[WIDTH-1] ^ B[WIDTH-1]);
            neg_r     <= signed_in && A[WIDTH-1];
            b_zero    <= (B == '0);
            divzero_q <= 1'b0;
            cnt       <= CNT_W'(WIDTH - 1);
          end
        end
        CALC: begin
          cnt <= cnt - CNT_W'(1);
          if (is_div) begin
            rem              <= rem_diff[WIDTH+1] ? rem_sh[WIDTH:0] : rem_diff[WIDTH:0];
            acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], ~rem_diff[WIDTH+1]};
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
        end
        FIX: begin
          if (is_div && b_zero) begin
            hi_q      <= a_orig;
            lo_q      <= '1;
            divzero_q <= 1'b1;
          end else begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign Busy    = (state != IDLE);
  assign Done    = done_q;
  assign DivZero = divzero_q;
  assign Hi      = hi_q;
  assign Lo      = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit; latency expectations follow MULDIV_FAST_MUL_EN.
module tb_mul_div_unit;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [1:0]  Op = 2'b00;
  logic [31:0] A = '0, B = '0, WData = '0;
  logic        HiWrite = 1'b0, LoWrite = 1'b0;
  logic        Busy, Done, DivZero;
  logic [31:0] Hi, Lo;

  int checks = 0;
  int errors = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .HiWrite(HiWrite), .LoWrite(LoWrite), .WData(WData),
    .Busy(Busy), .Done(Done), .DivZero(DivZero), .Hi(Hi), .Lo(Lo)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Launch one op at cycle 0, then watch Busy/Done until the result lands.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic exp_dz);
    int lat, busy_n, done_at;
    lat = (FAST && !op[1]) ? 2 : 34;
    @(negedge Clock);
    Start = 1'b1; Op = op; A = a; B = b;
    @(negedge Clock);
    Start = 1'b0; A = ~a; B = ~b;
    busy_n = 0;
    done_at = -1;
    chk({tag, " dz_clr"}, 64'(DivZero), 64'(0));
    for (int c = 1; c <= 40 && done_at < 0; c++) begin
      if (c > 1) @(negedge Clock);
      if (Busy) busy_n++;
      if (Done) done_at = c;
    end
    chk({tag, " done_cyc"}, 64'(done_at), 64'(lat));
    chk({tag, " busy_cyc"}, 64'(busy_n), 64'(lat - 1));
    chk({tag, " hi"}, 64'(Hi), 64'(exp_hi));
    chk({tag, " lo"}, 64'(Lo), 64'(exp_lo));
    chk({tag, " dz"}, 64'(DivZero), 64'(exp_dz));
    @(negedge Clock);
    chk({tag, " done_1cyc"}, 64'(Done), 64'(0));
  endtask

  initial begin
    int pulses;
    #3 Reset = 1'b0;
    @(negedge Clock);
    chk("rst busy", 64'(Busy), 64'(0));
    chk("rst done", 64'(Done), 64'(0));
    chk("rst dz", 64'(DivZero), 64'(0));
    chk("rst hi", 64'(Hi), 64'(0));
    chk("rst lo", 64'(Lo), 64'(0));
    @(negedge Clock);
    Reset = 1'b1;

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("mult_min",  2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
    run_op("div_n7_2",  2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div_7_n2",  2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    run_op("div_n7_n2", 2'b10, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0);
    run_op("divu_7_2",  2'b11, 32'd7,         32'd2,         32'h0000_0001, 32'h0000_0003, 1'b0);
    run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    run_op("divu_z",    2'b11, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
    run_op("multu_2_3", 2'b01, 32'd2,         32'd3,         32'h0000_0000, 32'h0000_0006, 1'b0);
    run_op("div_z_neg", 2'b10, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);

    // DIVU 100/7 with MTHI alongside Start, then Start/MTHI while busy
    @(negedge Clock);
    Start = 1'b1; Op = 2'b11; A = 32'd100; B = 32'd7; HiWrite = 1'b1; WData = 32'hAA;
    for (int c = 1; c <= 36; c++) begin
      @(negedge Clock);
      Start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
      if (c == 1)  chk("mthi_w_start", 64'(Hi), 64'hAA);
      if (c == 10) begin Start = 1'b1; Op = 2'b01; A = 32'd3; B = 32'd3; end
      if (c == 12) begin HiWrite = 1'b1; WData = 32'h55; end
      if (c == 33) chk("ign busy33", 64'(Busy), 64'(1));
      if (c == 34) begin
        chk("ign done34", 64'(Done), 64'(1));
        chk("ign hi", 64'(Hi), 64'(2));
        chk("ign lo", 64'(Lo), 64'(14));
      end
      if (c == 35) begin
        chk("ign no_restart", 64'(Busy), 64'(0));
        HiWrite = 1'b1; LoWrite = 1'b1; WData = 32'h55;
      end
      if (c == 36) begin
        chk("mthi idle", 64'(Hi), 64'h55);
        chk("mtlo idle", 64'(Lo), 64'h55);
      end
    end

    // reset in cycle 15 of a DIV
    @(negedge Clock);
    Start = 1'b1; Op = 2'b10; A = 32'hFFFF_FFF9; B = 32'd2;
    for (int c = 1; c <= 15; c++) begin
      @(negedge Clock);
      Start = 1'b0;
    end
    Reset = 1'b0;
    #1;
    chk("rst_mid busy", 64'(Busy), 64'(0));
    chk("rst_mid hi", 64'(Hi), 64'(0));
    chk("rst_mid lo", 64'(Lo), 64'(0));
    @(negedge Clock);
    Reset = 1'b1;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clock);
      if (Done || Busy) pulses++;
    end
    chk("rst_mid no_done", 64'(pulses), 64'(0));

    run_op("mult_5_6", 2'b00, 32'd5, 32'd6, 32'h0000_0000, 32'd30, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
